// File: rtl/gps_pkg.sv
// Shared types and helpers for the correlator-to-SPI result path.
package gps_pkg;

    localparam int unsigned SPI_WORD_W = 32;
    localparam int unsigned FA_W       = 14;

    // Integrate-and-dump sequencer states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INTEGRATE = 2'd1,
        ST_DUMP_WAIT = 2'd2
    } sched_state_e;

    // Layout of one result word on the SPI link
    typedef struct packed {
        logic [1:0]      pad_sin;
        logic [FA_W-1:0] fa_sin;
        logic [1:0]      pad_cos;
        logic [FA_W-1:0] fa_cos;
    } fa_word_t;

    // Pack a sin/cos accumulation pair into {2'b00, sin, 2'b00, cos}
    function automatic logic [SPI_WORD_W-1:0] pack_fa_word(
        input logic [FA_W-1:0] fa_sin,
        input logic [FA_W-1:0] fa_cos
    );
        fa_word_t w;
        w.pad_sin = 2'b00;
        w.fa_sin  = fa_sin;
        w.pad_cos = 2'b00;
        w.fa_cos  = fa_cos;
        return SPI_WORD_W'(w);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rptr_q];

    // Accept pops when non-empty; accept pushes when space exists or a pop frees a slot
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dump_scheduler.sv
// Epoch sequencer: strobes dump to demod, buffers the results and feeds spi_transceiver.
module dump_scheduler
    import gps_pkg::*;
#(
    parameter int unsigned EPOCH_CYCLES = 10000,
    parameter int unsigned DUMP_TIMEOUT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  sync,
    output logic                  dump,
    input  logic [FA_W-1:0]       fa_out_sin,
    input  logic [FA_W-1:0]       fa_out_cos,
    input  logic                  fa_ready,
    output logic [SPI_WORD_W-1:0] tx_word,
    output logic                  tx_trigger,
    input  logic                  tx_busy,
    output logic                  overflow,
    output logic                  timeout,
    output logic [15:0]           epoch_count
);

    localparam int unsigned CNT_W = $clog2(EPOCH_CYCLES);
    localparam int unsigned TO_W  = $clog2(DUMP_TIMEOUT + 1);

    sched_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TO_W-1:0]       wait_q, wait_d;
    logic                  dump_q, dump_d;
    logic [15:0]           epoch_q, epoch_d;
    logic                  ovf_q, ovf_d;
    logic                  to_q, to_d;
    logic                  epoch_end_c;
    logic                  push_c;

    logic [SPI_WORD_W-1:0] tx_word_q, tx_word_d;
    logic                  tx_trig_q, tx_trig_d;
    logic                  guard_q, guard_d;
    logic                  seen_busy_q, seen_busy_d;
    logic                  gcnt_q, gcnt_d;
    logic                  pop_c;

    logic [SPI_WORD_W-1:0] fifo_rdata;
    logic                  fifo_full, fifo_empty;

    sync_fifo #(
        .WIDTH (SPI_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .wdata_i (pack_fa_word(fa_out_sin, fa_out_cos)),
        .pop_i   (pop_c),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Epoch counting, dump strobe, result capture and sticky flags
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        dump_d      = 1'b0;
        epoch_d     = epoch_q;
        ovf_d       = ovf_q;
        to_d        = to_q;
        push_c      = 1'b0;
        epoch_end_c = (cnt_q == CNT_W'(EPOCH_CYCLES - 1));

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            wait_d  = '0;
        end else if (sync) begin
            // Restart the epoch; buffered words and the TX side are left alone
            state_d = ST_INTEGRATE;
            cnt_d   = '0;
            wait_d  = '0;
            epoch_d = '0;
            ovf_d   = 1'b0;
            to_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_INTEGRATE;
                    cnt_d   = '0;
                end
                ST_INTEGRATE, ST_DUMP_WAIT: begin
                    cnt_d = epoch_end_c ? '0 : cnt_q + CNT_W'(1);
                    if (state_q == ST_DUMP_WAIT) begin
                        if (fa_ready) begin
                            push_c  = 1'b1;
                            state_d = ST_INTEGRATE;
                        end else if (wait_q == TO_W'(DUMP_TIMEOUT - 1)) begin
                            to_d    = 1'b1;
                            state_d = ST_INTEGRATE;
                        end else begin
                            wait_d = wait_q + TO_W'(1);
                        end
                    end
                    // Epochs stay contiguous regardless of the result handshake
                    if (epoch_end_c) begin
                        dump_d  = 1'b1;
                        epoch_d = epoch_q + 16'd1;
                        state_d = ST_DUMP_WAIT;
                        wait_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (push_c && fifo_full && !pop_c) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            dump_q  <= 1'b0;
            epoch_q <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            dump_q  <= dump_d;
            epoch_q <= epoch_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end

    // TX launch and guard: wait for busy high-then-low, or give up after 2 idle cycles
    always_comb begin
        pop_c       = !fifo_empty && !tx_busy && !guard_q;
        tx_word_d   = tx_word_q;
        tx_trig_d   = pop_c;
        guard_d     = guard_q;
        seen_busy_d = seen_busy_q;
        gcnt_d      = gcnt_q;
        if (pop_c) begin
            tx_word_d   = fifo_rdata;
            guard_d     = 1'b1;
            seen_busy_d = 1'b0;
            gcnt_d      = 1'b0;
        end else if (guard_q) begin
            if (seen_busy_q) begin
                if (!tx_busy) begin
                    guard_d = 1'b0;
                end
            end else if (tx_busy) begin
                seen_busy_d = 1'b1;
            end else if (gcnt_q) begin
                guard_d = 1'b0;
            end else begin
                gcnt_d = 1'b1;
            end
        end
    end

    // TX registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_word_q   <= '0;
            tx_trig_q   <= 1'b0;
            guard_q     <= 1'b0;
            seen_busy_q <= 1'b0;
            gcnt_q      <= 1'b0;
        end else begin
            tx_word_q   <= tx_word_d;
            tx_trig_q   <= tx_trig_d;
            guard_q     <= guard_d;
            seen_busy_q <= seen_busy_d;
            gcnt_q      <= gcnt_d;
        end
    end

    assign dump        = dump_q;
    assign tx_word     = tx_word_q;
    assign tx_trigger  = tx_trig_q;
    assign overflow    = ovf_q;
    assign timeout     = to_q;
    assign epoch_count = epoch_q;

endmodule

// File: tb/tb_dump_scheduler.sv
// Bench for dump_scheduler: vector table for the steady-state epochs plus corner sequences.
module tb_dump_scheduler;

    localparam int unsigned EPOCH = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sync = 1'b0;
    logic        fa_ready = 1'b0;
    logic [13:0] fa_out_sin = '0;
    logic [13:0] fa_out_cos = '0;
    logic        dump, tx_trigger, overflow, timeout;
    logic [31:0] tx_word;
    logic [15:0] epoch_count;
    logic        tx_busy;
    logic        model_busy = 1'b0;
    logic        busy_force = 1'b0;
    int          busy_len = 5;
    int          busy_left = 0;

    assign tx_busy = model_busy | busy_force;

    dump_scheduler #(
        .EPOCH_CYCLES (EPOCH),
        .DUMP_TIMEOUT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sync        (sync),
        .dump        (dump),
        .fa_out_sin  (fa_out_sin),
        .fa_out_cos  (fa_out_cos),
        .fa_ready    (fa_ready),
        .tx_word     (tx_word),
        .tx_trigger  (tx_trigger),
        .tx_busy     (tx_busy),
        .overflow    (overflow),
        .timeout     (timeout),
        .epoch_count (epoch_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] word;
        int          at;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [13:0] s;
        logic [13:0] c;
        logic [31:0] w;
        logic [15:0] ep;
    } vec_t;
    vec_t tbl[6];

    int n_vec = 0;
    int n_err = 0;
    int trig_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every trigger must match the oldest expected word
    always @(negedge clk) begin
        if (tx_trigger) begin
            trig_cnt++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_trigger: tx_word %h, nothing expected (cycle %0d)", tx_word, cyc);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("tx_word", tx_word, e.word);
                if (e.at >= 0) check("trigger_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Transceiver model: busy for busy_len cycles after each trigger
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_left = 0;
            model_busy = 1'b0;
        end else begin
            if (tx_trigger && busy_len > 0) busy_left = busy_len;
            if (busy_left > 0) begin
                model_busy = 1'b1;
                busy_left--;
            end else begin
                model_busy = 1'b0;
            end
        end
    end

    task automatic wait_dump(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dump) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dump_wait: no dump within %0d cycles", budget);
        end
    endtask

    // Answer a dump with fa_ready three cycles later
    task automatic respond(input vec_t v, input bit expect_tx, input bit timed);
        sb_t e;
        repeat (3) @(posedge clk);
        #1;
        fa_out_sin = v.s;
        fa_out_cos = v.c;
        fa_ready = 1'b1;
        if (expect_tx) begin
            e.word = v.w;
            e.at = timed ? cyc + 2 : -1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        fa_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        sync = 1'b0;
        fa_ready = 1'b0;
        busy_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        trig_cnt = 0;
    endtask

    task automatic start(output int t_en);
        @(posedge clk);
        #1;
        enable = 1'b1;
        t_en = cyc + 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_en, at, d, tc, r;
        sb_t e;

        tbl[0] = '{14'h1ABC, 14'h0123, 32'h1ABC0123, 16'd1};
        tbl[1] = '{14'h1ABC, 14'h0123, 32'h1ABC0123, 16'd2};
        tbl[2] = '{14'h1ABC, 14'h0123, 32'h1ABC0123, 16'd3};
        tbl[3] = '{14'h3FFF, 14'h0000, 32'h3FFF0000, 16'd4};
        tbl[4] = '{14'h0000, 14'h3FFF, 32'h00003FFF, 16'd5};
        tbl[5] = '{14'h3FFF, 14'h3FFF, 32'h3FFF3FFF, 16'd6};

        // Reset state and idle behaviour
        do_reset();
        check("rst_dump", 32'(dump), 0);
        check("rst_tx_trigger", 32'(tx_trigger), 0);
        check("rst_tx_word", tx_word, 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_epoch_count", 32'(epoch_count), 0);

        // Steady-state epochs from the vector table
        busy_len = 5;
        start(t_en);
        for (int i = 0; i < 6; i++) begin
            wait_dump(150, at);
            check("dump_cycle", 32'(at - t_en), 32'(EPOCH * (i + 1)));
            check("epoch_count", 32'(epoch_count), 32'(tbl[i].ep));
            respond(tbl[i], 1'b1, 1'b1);
        end
        repeat (10) @(negedge clk);
        check("t1_drained", 32'(sb.size()), 0);
        check("t1_overflow", 32'(overflow), 0);
        check("t1_timeout", 32'(timeout), 0);

        // Long busy: one trigger, four buffered, sixth word dropped
        do_reset();
        busy_len = 500;
        start(t_en);
        for (int i = 0; i < 6; i++) begin
            wait_dump(150, at);
            if (i == 5) check("ovf_before", 32'(overflow), 0);
            respond(tbl[i], i < 5, 1'b0);
        end
        check("ovf_set", 32'(overflow), 1);
        enable = 1'b0;
        for (int k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
        repeat (600) @(negedge clk);
        check("ovf_trigger_total", 32'(trig_cnt), 5);
        check("ovf_drained", 32'(sb.size()), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Withheld fa_ready: timeout, no push, epoch spacing preserved
        do_reset();
        busy_len = 5;
        start(t_en);
        wait_dump(150, at);
        respond(tbl[3], 1'b1, 1'b1);
        wait_dump(150, d);
        tc = trig_cnt;
        repeat (15) @(negedge clk);
        check("timeout_at_15", 32'(timeout), 0);
        @(negedge clk);
        check("timeout_at_16", 32'(timeout), 1);
        repeat (14) @(posedge clk);
        #1;
        fa_ready = 1'b1;
        fa_out_sin = 14'h2222;
        fa_out_cos = 14'h1111;
        @(posedge clk);
        #1;
        fa_ready = 1'b0;
        wait_dump(150, at);
        check("timeout_next_dump", 32'(at - d), EPOCH);
        check("timeout_no_tx", 32'(trig_cnt), 32'(tc));

        // sync coincident with the last cycle of an epoch
        do_reset();
        start(t_en);
        wait_dump(150, d);
        repeat (98) @(posedge clk);
        #1;
        check("pre_sync_timeout", 32'(timeout), 1);
        check("pre_sync_epoch", 32'(epoch_count), 1);
        @(posedge clk);
        #1;
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
        check("sync_no_dump", 32'(dump), 0);
        check("sync_epoch", 32'(epoch_count), 0);
        check("sync_timeout", 32'(timeout), 0);
        check("sync_overflow", 32'(overflow), 0);
        wait_dump(250, at);
        check("sync_next_dump", 32'(at - d), 2 * EPOCH);
        check("sync_epoch_after", 32'(epoch_count), 1);

        // Asynchronous reset in DUMP_WAIT with two words queued and busy high
        do_reset();
        busy_len = 5;
        start(t_en);
        wait_dump(150, at);
        respond(tbl[3], 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        busy_force = 1'b1;
        wait_dump(150, at);
        respond(tbl[4], 1'b0, 1'b0);
        wait_dump(150, at);
        respond(tbl[5], 1'b0, 1'b0);
        wait_dump(150, at);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_epoch", 32'(epoch_count), 4);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_tx_word", tx_word, 0);
        check("async_dump", 32'(dump), 0);
        check("async_tx_trigger", 32'(tx_trigger), 0);
        check("async_epoch", 32'(epoch_count), 0);
        check("async_timeout", 32'(timeout), 0);
        check("async_overflow", 32'(overflow), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_force = 1'b0;
        tc = trig_cnt;
        t_en = cyc + 1;
        wait_dump(150, at);
        check("post_rst_dump", 32'(at - t_en), EPOCH);
        check("post_rst_no_tx", 32'(trig_cnt), 32'(tc));
        respond(tbl[0], 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("post_rst_one_tx", 32'(trig_cnt), 32'(tc + 1));

        // Busy never asserted: guard releases, triggers every 3 cycles in order
        do_reset();
        busy_len = 0;
        busy_force = 1'b1;
        start(t_en);
        for (int i = 3; i < 6; i++) begin
            wait_dump(150, at);
            respond(tbl[i], 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        busy_force = 1'b0;
        r = cyc;
        for (int i = 0; i < 3; i++) begin
            e.word = tbl[3 + i].w;
            e.at = r + 1 + 3 * i;
            sb.push_back(e);
        end
        repeat (12) @(negedge clk);
        check("guard_drained", 32'(sb.size()), 0);
        check("guard_trigger_total", 32'(trig_cnt), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
